// File: rtl/syn_lb_mux_pkg.sv
// -----------------------------------------------------------------------------
// syn_lb_mux_pkg
//   Shared types and helpers for the local-bus fabric syn_lb_mux.
//   - state_t      : fabric FSM states (IDLE, BUSY, RESP)
//   - op_t         : latched transaction kind (LB_RD, LB_WR)
//   - ERR_DATA_DEF : default read data returned with an error response
//   - slv_addr_w() : width of the shared slave address bus
// -----------------------------------------------------------------------------
package syn_lb_mux_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    LB_RD = 1'b0,
    LB_WR = 1'b1
  } op_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Slaves see only the address bits below the slave-select field.
  function automatic int unsigned slv_addr_w(input int unsigned addr_w,
                                             input int unsigned sel_w);
    return addr_w - sel_w;
  endfunction

endpackage

// File: rtl/syn_lb_timeout_cntr.sv
// -----------------------------------------------------------------------------
// syn_lb_timeout_cntr
//   Busy-cycle counter used by syn_lb_mux to give up on a silent slave.
//   Only instantiated when SYN_LB_MUX_TIMEOUT_EN is defined.
//
//   Ports:
//     clk_ir  in   clock
//     rst_il  in   asynchronous active-low reset
//     clr     in   hold the count at zero (fabric not waiting on a slave)
//     cnt_en  in   count one waiting cycle
//     expire  out  high in the LIMIT-th consecutive counted cycle; the count
//                  reaches LIMIT on the clock edge that ends this cycle
// -----------------------------------------------------------------------------
module syn_lb_timeout_cntr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_ir,
  input  logic rst_il,
  input  logic clr,
  input  logic cnt_en,
  output logic expire
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt_en && (cnt != CW'(LIMIT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = cnt_en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/syn_lb_mux.sv
// -----------------------------------------------------------------------------
// syn_lb_mux
//   Local-bus fabric: one host-side LB master fanned out to NUM_SLV LB slaves.
//   The slave is picked by the top SEL_W address bits; one transaction is in
//   flight at a time. Unmapped addresses, dropped requests (issued while a
//   transaction is in flight) and read+write collisions are answered with
//   mst_err. All outputs are registered.
//
//   Optional build macro: SYN_LB_MUX_TIMEOUT_EN
//     defined   : a slave silent for TIMEOUT_CYC busy cycles gets an error
//                 response (rd_data = ERR_DATA)
//     undefined : the fabric waits for the slave indefinitely
//
//   Ports:
//     clk_ir        in   clock
//     rst_il        in   asynchronous active-low reset
//     mst_rd_en     in   master read request pulse
//     mst_wr_en     in   master write request pulse
//     mst_addr      in   master address [ADDR_W]
//     mst_wr_data   in   master write data [DATA_W]
//     mst_wr_valid  out  write-complete pulse
//     mst_rd_valid  out  read-data-valid pulse
//     mst_rd_data   out  read data, held between reads
//     mst_err       out  error pulse
//     slv_rd_en     out  one-hot per-slave read pulse [NUM_SLV]
//     slv_wr_en     out  one-hot per-slave write pulse [NUM_SLV]
//     slv_addr      out  shared slave address [ADDR_W-SEL_W]
//     slv_wr_data   out  shared slave write data [DATA_W]
//     slv_wr_valid  in   per-slave write ack [NUM_SLV]
//     slv_rd_valid  in   per-slave read valid [NUM_SLV]
//     slv_rd_data   in   packed read data, slave i at [i*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module syn_lb_mux
  import syn_lb_mux_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 12,
  parameter int unsigned       NUM_SLV     = 4,
  parameter int unsigned       SEL_W       = 4,
  parameter int unsigned       TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ERR_DATA_DEF)
) (
  input  logic                                 clk_ir,
  input  logic                                 rst_il,
  input  logic                                 mst_rd_en,
  input  logic                                 mst_wr_en,
  input  logic [ADDR_W-1:0]                    mst_addr,
  input  logic [DATA_W-1:0]                    mst_wr_data,
  output logic                                 mst_wr_valid,
  output logic                                 mst_rd_valid,
  output logic [DATA_W-1:0]                    mst_rd_data,
  output logic                                 mst_err,
  output logic [NUM_SLV-1:0]                   slv_rd_en,
  output logic [NUM_SLV-1:0]                   slv_wr_en,
  output logic [slv_addr_w(ADDR_W, SEL_W)-1:0] slv_addr,
  output logic [DATA_W-1:0]                    slv_wr_data,
  input  logic [NUM_SLV-1:0]                   slv_wr_valid,
  input  logic [NUM_SLV-1:0]                   slv_rd_valid,
  input  logic [NUM_SLV*DATA_W-1:0]            slv_rd_data
);

  localparam int unsigned SLV_AW = slv_addr_w(ADDR_W, SEL_W);

  state_t             state;
  op_t                op_q;
  logic [SEL_W-1:0]   sel_q;
  logic               coll_q;   // read dropped in favour of a simultaneous write

  logic [SEL_W-1:0]   req_sel;
  logic               req;
  logic               req_mapped;
  logic [NUM_SLV-1:0] req_oh;
  logic [NUM_SLV-1:0] lat_oh;
  logic               acc_vld;
  logic [DATA_W-1:0]  lat_rd_data;
  logic               tmo_expire;

  assign req_sel    = mst_addr[ADDR_W-1 -: SEL_W];
  assign req        = mst_rd_en | mst_wr_en;
  assign req_mapped = 32'(req_sel) < NUM_SLV;

  // One-hot decode of the incoming and latched selects; built by comparison
  // so that a select field wider than the slave count never indexes out of range.
  always_comb begin
    req_oh      = '0;
    lat_oh      = '0;
    lat_rd_data = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      req_oh[i] = (req_sel == SEL_W'(i));
      lat_oh[i] = (sel_q == SEL_W'(i));
      if (sel_q == SEL_W'(i)) begin
        lat_rd_data = slv_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Only the latched slave's valid for the latched op completes a transaction.
  assign acc_vld = (op_q == LB_WR) ? |(slv_wr_valid & lat_oh)
                                   : |(slv_rd_valid & lat_oh);

`ifdef SYN_LB_MUX_TIMEOUT_EN
  syn_lb_timeout_cntr #(
    .LIMIT (TIMEOUT_CYC)
  ) u_tmo (
    .clk_ir (clk_ir),
    .rst_il (rst_il),
    .clr    (state != BUSY),
    .cnt_en (state == BUSY),
    .expire (tmo_expire)
  );
`else
  // TIMEOUT_CYC only matters when the timeout counter is built in.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo_expire     = 1'b0;
`endif

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state        <= IDLE;
      op_q         <= LB_RD;
      sel_q        <= '0;
      coll_q       <= 1'b0;
      mst_wr_valid <= 1'b0;
      mst_rd_valid <= 1'b0;
      mst_rd_data  <= '0;
      mst_err      <= 1'b0;
      slv_rd_en    <= '0;
      slv_wr_en    <= '0;
      slv_addr     <= '0;
      slv_wr_data  <= '0;
    end else begin
      // Every master/slave strobe is a single-cycle pulse.
      mst_wr_valid <= 1'b0;
      mst_rd_valid <= 1'b0;
      mst_err      <= 1'b0;
      slv_rd_en    <= '0;
      slv_wr_en    <= '0;

      case (state)
        IDLE: begin
          if (req) begin
            op_q        <= mst_wr_en ? LB_WR : LB_RD;
            coll_q      <= mst_wr_en & mst_rd_en;
            sel_q       <= req_sel;
            slv_addr    <= mst_addr[SLV_AW-1:0];
            slv_wr_data <= mst_wr_data;
            if (req_mapped) begin
              if (mst_wr_en) slv_wr_en <= req_oh;
              else           slv_rd_en <= req_oh;
              state <= BUSY;
            end else begin
              state <= RESP;
            end
          end
        end

        BUSY: begin
          // A request arriving now is dropped and flagged next cycle.
          mst_err <= req;
          if (acc_vld || tmo_expire) begin
            // A slave valid on the expiry cycle takes precedence.
            if (op_q == LB_WR) begin
              mst_wr_valid <= 1'b1;
            end else begin
              mst_rd_valid <= 1'b1;
              mst_rd_data  <= acc_vld ? lat_rd_data : ERR_DATA;
            end
            mst_err <= req | coll_q | ~acc_vld;
            state   <= IDLE;
          end
        end

        RESP: begin
          // Unmapped address: error response one cycle after the decode.
          if (op_q == LB_WR) begin
            mst_wr_valid <= 1'b1;
          end else begin
            mst_rd_valid <= 1'b1;
            mst_rd_data  <= ERR_DATA;
          end
          mst_err <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syn_lb_mux.sv
module tb_syn_lb_mux;

  localparam int          WIN = 20;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic         clk_ir;
  logic         rst_il;
  logic         mst_rd_en, mst_wr_en;
  logic [11:0]  mst_addr;
  logic [31:0]  mst_wr_data;
  logic         mst_wr_valid, mst_rd_valid, mst_err;
  logic [31:0]  mst_rd_data;
  logic [3:0]   slv_rd_en, slv_wr_en;
  logic [7:0]   slv_addr;
  logic [31:0]  slv_wr_data;
  logic [3:0]   slv_wr_valid, slv_rd_valid;
  logic [127:0] slv_rd_data;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] last_rd;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          lat;        // cycles from slave enable to slave valid
    logic [31:0] rdata;
    int          spur_slv;   // another slave pulsing rd_valid while busy
    int          spur_cyc;
    int          drop_cyc;   // cycle of an extra master request (0 = none)
    logic [3:0]  exp_rd_en;
    logic [3:0]  exp_wr_en;
    logic [7:0]  exp_slv_addr;
    logic [31:0] exp_rv;     // bit c set: mst_rd_valid in cycle c after request
    logic [31:0] exp_wv;
    logic [31:0] exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [9];

  syn_lb_mux #(
    .DATA_W      (32),
    .ADDR_W      (12),
    .NUM_SLV     (4),
    .SEL_W       (4),
    .TIMEOUT_CYC (8),
    .ERR_DATA    (32'hDEAD_BEEF)
  ) dut (
    .clk_ir       (clk_ir),
    .rst_il       (rst_il),
    .mst_rd_en    (mst_rd_en),
    .mst_wr_en    (mst_wr_en),
    .mst_addr     (mst_addr),
    .mst_wr_data  (mst_wr_data),
    .mst_wr_valid (mst_wr_valid),
    .mst_rd_valid (mst_rd_valid),
    .mst_rd_data  (mst_rd_data),
    .mst_err      (mst_err),
    .slv_rd_en    (slv_rd_en),
    .slv_wr_en    (slv_wr_en),
    .slv_addr     (slv_addr),
    .slv_wr_data  (slv_wr_data),
    .slv_wr_valid (slv_wr_valid),
    .slv_rd_valid (slv_rd_valid),
    .slv_rd_data  (slv_rd_data)
  );

  initial clk_ir = 1'b0;
  always #5 clk_ir = ~clk_ir;

  task automatic step();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: derives the master-visible outcome of one
  // request from the address map and the slave's response latency.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   sel;
    bit   mapped;
    int   resp;
    r      = v;
    sel    = int'(v.addr[11:8]);
    mapped = (sel < 4);
    resp   = mapped ? v.lat + 2 : 2;
    r.exp_rd_en    = (mapped && !v.wr) ? 4'(1 << sel) : 4'h0;
    r.exp_wr_en    = (mapped &&  v.wr) ? 4'(1 << sel) : 4'h0;
    r.exp_slv_addr = v.addr[7:0];
    r.exp_rv       = v.wr ? 32'h0 : (32'h1 << resp);
    r.exp_wv       = v.wr ? (32'h1 << resp) : 32'h0;
    r.exp_err      = 32'h0;
    if (!mapped || (v.rd && v.wr)) r.exp_err |= (32'h1 << resp);
    if (v.drop_cyc != 0)           r.exp_err |= (32'h1 << (v.drop_cyc + 1));
    r.exp_rdata    = mapped ? v.rdata : ERR;
    return r;
  endfunction

  // Applies one request, plays the addressed slave (and any spurious slave or
  // extra master request), records master strobes per cycle and compares.
  task automatic run_txn(input vec_t v, input string tag);
    logic [31:0] rv_m, wv_m, er_m, rd_at_rv;
    logic [3:0]  extra_en;
    int          tgt;
    rv_m = '0; wv_m = '0; er_m = '0; rd_at_rv = '0; extra_en = '0;
    tgt  = int'(v.addr[11:8]);
    for (int s = 0; s < 4; s++) slv_rd_data[s*32 +: 32] = $urandom;
    mst_addr    = v.addr;
    mst_wr_data = v.wdata;
    mst_rd_en   = v.rd;
    mst_wr_en   = v.wr;
    step();
    mst_rd_en   = 1'b0;
    mst_wr_en   = 1'b0;
    mst_addr    = 12'($urandom);
    mst_wr_data = $urandom;
    check({tag, " slv_rd_en"}, 32'(slv_rd_en), 32'(v.exp_rd_en));
    check({tag, " slv_wr_en"}, 32'(slv_wr_en), 32'(v.exp_wr_en));
    if ((v.exp_rd_en | v.exp_wr_en) != 4'h0) begin
      check({tag, " slv_addr"}, 32'(slv_addr), 32'(v.exp_slv_addr));
      if (v.wr) check({tag, " slv_wr_data"}, slv_wr_data, v.wdata);
    end
    for (int c = 1; c <= WIN; c++) begin
      if (c >= 2) extra_en |= slv_rd_en | slv_wr_en;
      if (mst_rd_valid) begin
        rv_m[c]  = 1'b1;
        rd_at_rv = mst_rd_data;
      end
      if (mst_wr_valid) wv_m[c] = 1'b1;
      if (mst_err)      er_m[c] = 1'b1;
      if (tgt < 4 && c == 1 + v.lat) begin
        if (v.wr) begin
          slv_wr_valid[tgt] = 1'b1;
        end else begin
          slv_rd_valid[tgt] = 1'b1;
          slv_rd_data[tgt*32 +: 32] = v.rdata;
        end
      end
      if (c == v.spur_cyc) slv_rd_valid[v.spur_slv] = 1'b1;
      if (c == v.drop_cyc) mst_rd_en = 1'b1;
      step();
      slv_rd_valid = '0;
      slv_wr_valid = '0;
      mst_rd_en    = 1'b0;
    end
    check({tag, " rd_valid cycles"}, rv_m, v.exp_rv);
    check({tag, " wr_valid cycles"}, wv_m, v.exp_wv);
    check({tag, " err cycles"},      er_m, v.exp_err);
    check({tag, " stray slave enables"}, 32'(extra_en), 32'h0);
    if (!v.wr) begin
      check({tag, " rd_data"}, rd_at_rv, v.exp_rdata);
      last_rd = v.exp_rdata;
    end else begin
      check({tag, " rd_data held"}, mst_rd_data, last_rd);
    end
    if ((v.exp_rd_en | v.exp_wr_en) != 4'h0)
      check({tag, " slv_addr held"}, 32'(slv_addr), 32'(v.exp_slv_addr));
    step();
  endtask

  initial begin
    vec_t v;
    int   pulses;

    rst_il       = 1'b0;
    mst_rd_en    = 1'b0;
    mst_wr_en    = 1'b0;
    mst_addr     = '0;
    mst_wr_data  = '0;
    slv_wr_valid = '0;
    slv_rd_valid = '0;
    slv_rd_data  = '0;
    last_rd      = '0;

    tbl = '{
      '{1'b1, 1'b0, 12'h234, 32'h0,         3, 32'h1234_5678, 0, 0, 0,
        4'b0100, 4'b0000, 8'h34, 32'h20, 32'h0,  32'h0,  32'h1234_5678},
      '{1'b0, 1'b1, 12'h010, 32'hA5A5_A5A5, 1, 32'h0,         0, 0, 0,
        4'b0000, 4'b0001, 8'h10, 32'h0,  32'h08, 32'h0,  32'h0},
      '{1'b1, 1'b0, 12'hF00, 32'h0,         0, 32'h0,         0, 0, 0,
        4'b0000, 4'b0000, 8'h00, 32'h04, 32'h0,  32'h04, 32'hDEAD_BEEF},
      '{1'b1, 1'b0, 12'h3AB, 32'h0,         4, 32'h0BAD_F00D, 1, 2, 3,
        4'b1000, 4'b0000, 8'hAB, 32'h40, 32'h0,  32'h10, 32'h0BAD_F00D},
      '{1'b1, 1'b1, 12'h1FF, 32'h0000_00FF, 0, 32'h0,         0, 0, 0,
        4'b0000, 4'b0010, 8'hFF, 32'h0,  32'h04, 32'h04, 32'h0},
      '{1'b0, 1'b1, 12'h400, 32'h1111_2222, 0, 32'h0,         0, 0, 0,
        4'b0000, 4'b0000, 8'h00, 32'h0,  32'h04, 32'h04, 32'h0},
      '{1'b0, 1'b1, 12'h3C0, 32'hCAFE_0001, 2, 32'h0,         0, 0, 1,
        4'b0000, 4'b1000, 8'hC0, 32'h0,  32'h10, 32'h04, 32'h0},
      '{1'b1, 1'b0, 12'h101, 32'h0,         0, 32'hFFFF_0000, 0, 0, 0,
        4'b0010, 4'b0000, 8'h01, 32'h04, 32'h0,  32'h0,  32'hFFFF_0000},
      '{1'b1, 1'b0, 12'hA00, 32'h0,         0, 32'h0,         0, 0, 1,
        4'b0000, 4'b0000, 8'h00, 32'h04, 32'h0,  32'h04, 32'hDEAD_BEEF}
    };

    // Reset state
    step();
    step();
    check("reset strobes", {29'h0, mst_rd_valid, mst_wr_valid, mst_err}, 32'h0);
    check("reset slv enables", {24'h0, slv_rd_en, slv_wr_en}, 32'h0);
    check("reset rd_data", mst_rd_data, 32'h0);
    rst_il = 1'b1;
    step();

    // Directed table
    for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

`ifdef SYN_LB_MUX_TIMEOUT_EN
    // Silent slave: error after 8 busy cycles, late valid at cycle 12 ignored.
    v = '{1'b1, 1'b0, 12'h120, 32'h0, 11, 32'h5555_AAAA, 0, 0, 0,
          4'b0010, 4'b0000, 8'h20, 32'h200, 32'h0, 32'h200, 32'hDEAD_BEEF};
    run_txn(v, "tmo_silent");
    // Valid exactly on the expiry cycle wins.
    v = '{1'b1, 1'b0, 12'h120, 32'h0, 7, 32'h7777_1111, 0, 0, 0,
          4'b0010, 4'b0000, 8'h20, 32'h200, 32'h0, 32'h0, 32'h7777_1111};
    run_txn(v, "tmo_edge");
`endif

    // Async reset in the middle of a transaction
    mst_addr  = 12'h25A;
    mst_rd_en = 1'b1;
    step();
    mst_rd_en = 1'b0;
    check("rst pre slv_rd_en", 32'(slv_rd_en), 32'h4);
    rst_il = 1'b0;
    #1;
    check("rst strobes", {29'h0, mst_rd_valid, mst_wr_valid, mst_err}, 32'h0);
    check("rst slv enables", {24'h0, slv_rd_en, slv_wr_en}, 32'h0);
    check("rst slv_addr", 32'(slv_addr), 32'h0);
    check("rst slv_wr_data", slv_wr_data, 32'h0);
    check("rst rd_data", mst_rd_data, 32'h0);
    step();
    step();
    rst_il  = 1'b1;
    last_rd = 32'h0;
    slv_rd_valid[2] = 1'b1;
    slv_rd_data[2*32 +: 32] = 32'h9999_0000;
    step();
    slv_rd_valid = '0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      pulses += int'(mst_rd_valid) + int'(mst_wr_valid) + int'(mst_err);
      step();
    end
    check("rst late response pulses", 32'(pulses), 32'h0);
    check("rst late response rd_data", mst_rd_data, 32'h0);

    // Randomised transactions against the reference model
    for (int k = 0; k < 40; k++) begin
      int sel;
      int busy_len;
      sel     = $urandom_range(0, 5);
      v.rd    = 1'($urandom_range(0, 1));
      v.wr    = 1'($urandom_range(0, 1));
      if (!v.rd && !v.wr) v.rd = 1'b1;
      v.addr  = {4'(sel), 8'($urandom)};
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.lat   = $urandom_range(0, 5);
      busy_len   = (sel < 4) ? v.lat + 1 : 1;
      v.drop_cyc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, busy_len) : 0;
      v.spur_slv = (sel + 1) % 4;
      v.spur_cyc = (sel < 4 && $urandom_range(0, 2) == 0) ? $urandom_range(1, busy_len) : 0;
      v = model(v);
      run_txn(v, $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/syn_lb_mux.md
Name: syn_lb_mux

Overview:
- Parametrised local-bus fabric. Connects one host-side LB master to NUM_SLV LB slaves and routes each transaction by decoding the upper address bits.
- Tracks one outstanding transaction at a time and returns the selected slave's response to the master.
- Answers transactions to unmapped addresses, and (optionally) to hung slaves, with an error response.
- Sits between the host bridge and the per-block register slaves; generalises the single master/slave LB pairing to N channels.

Parameters:
- DATA_W, 32, data width, both sides
- ADDR_W, 12, master address width
- NUM_SLV, 4, number of slave channels (1..16)
- SEL_W, 4, upper address bits used as slave index; slave address width = ADDR_W-SEL_W
- TIMEOUT_CYC, 255, cycles waited for slave response before error (timeout feature only)
- ERR_DATA, 32'hDEAD_BEEF, rd_data returned on error

Ports:
- clk_ir  in  1  clock
- rst_il  in  1  asynchronous active-low reset
- mst_rd_en  in  1  master read request, 1-cycle pulse
- mst_wr_en  in  1  master write request, 1-cycle pulse
- mst_addr  in  ADDR_W  master address
- mst_wr_data  in  DATA_W  master write data
- mst_wr_valid  out  1  write-complete pulse to master
- mst_rd_valid  out  1  read-data-valid pulse to master
- mst_rd_data  out  DATA_W  read data to master
- mst_err  out  1  error pulse (unmapped, timeout, dropped or collided request)
- slv_rd_en  out  NUM_SLV  per-slave read pulse, one-hot
- slv_wr_en  out  NUM_SLV  per-slave write pulse, one-hot
- slv_addr  out  ADDR_W-SEL_W  shared slave address, lower bits of mst_addr
- slv_wr_data  out  DATA_W  shared slave write data
- slv_wr_valid  in  NUM_SLV  per-slave write ack
- slv_rd_valid  in  NUM_SLV  per-slave read valid
- slv_rd_data  in  NUM_SLV*DATA_W  packed read data; slave i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset: every output 0. The state, latched index, latched op and counter all clear. The async assert takes effect immediately, including mid-transaction; any late slave response after release is ignored.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE, request seen at cycle N:
  - sel = mst_addr[ADDR_W-1 -: SEL_W].
  - If sel < NUM_SLV: at cycle N+1 pulse slv_rd_en[sel] or slv_wr_en[sel] for one cycle. slv_addr and slv_wr_data are registered and held until the next request. Latch sel and op; go to BUSY.
  - If sel >= NUM_SLV: go to RESP; at N+1 prepare error response; at N+2 pulse mst_rd_valid (read) or mst_wr_valid (write), together with mst_err. For reads, mst_rd_data = ERR_DATA.
- rd_en and wr_en together in IDLE: treated as a write; read dropped; mst_err pulses with the write's completion.
- BUSY:
  - Only the latched slave's valid matching the latched op is accepted. All other slave valids are ignored.
  - Accepted valid at cycle M: at M+1 pulse the matching mst_*_valid; for reads, register slv_rd_data[sel] into mst_rd_data; return to IDLE.
  - A new master request while BUSY or RESP is dropped: not forwarded, mst_err pulses the next cycle.
  - Slave valid and a new master request in the same cycle: the response completes and the request is dropped with an error.
- mst_rd_data holds its last value between reads; it is not cleared on writes.
- Throughput: at most one transaction per 3 cycles (request, slave enable, response minimum).

Optional Feature:
- Macro SYN_LB_MUX_TIMEOUT_EN.
- With macro defined:
  - BUSY runs a counter of width $clog2(TIMEOUT_CYC+1), cleared on entry.
  - When it reaches TIMEOUT_CYC with no accepted valid, the next cycle pulses mst_*_valid and mst_err (rd_data = ERR_DATA), then the FSM returns to IDLE.
  - A slave valid on the expiry cycle wins: normal response, no error.
  - A late slave response after timeout is ignored.
- Without macro: no counter; BUSY waits indefinitely.

Decomposition:
- Package syn_lb_mux_pkg holds:
  - FSM state enum (IDLE, BUSY, RESP)
  - op enum (LB_RD, LB_WR)
  - default ERR_DATA constant
  - function computing slave-address width
- One natural sub-module, syn_lb_timeout_cntr: load/clear/expire counter, instantiated only under the macro.

Test Plan:
- Read to slave 2 at addr 0x2_34; slave 2 asserts rd_valid with data 0x1234_5678 three cycles after slv_rd_en[2] -> slv_addr = 0x34; mst_rd_valid one cycle later with 0x1234_5678; mst_err = 0.
- Write 0xA5A5_A5A5 to slave 0 addr 0x0_10 with an immediate ack -> slv_wr_en = 4'b0001, slv_wr_data correct, mst_wr_valid at N+3, no err.
- Read at addr 0xF_00 with NUM_SLV = 4 -> no slv enables; mst_rd_valid + mst_err at N+2; data 0xDEAD_BEEF.
- During BUSY: slave 1 pulses rd_valid while the latched slave is 3, and a second master rd_en is issued -> slave 1 response ignored; second request dropped with mst_err; slave 3 response completes normally.
- Macro on, TIMEOUT_CYC = 8, slave silent -> mst_rd_valid + mst_err + 0xDEAD_BEEF after 8 BUSY cycles; slave valid at cycle 12 ignored. Repeat with the valid exactly on the expiry cycle -> normal data, no err.
- Assert rst_il low in BUSY -> all outputs 0 immediately; after release, a pending slave valid produces no master response.
